// File: rtl/timer_bank_if.sv
// Memory-mapped slave bus between the south bridge and the timer bank.
// Word-addressed, single-cycle writes, combinational read data.
interface timer_bank_if;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        Hit;

    modport master (output Addr, WE, Din, input Dout, Hit);
    modport slave  (input Addr, WE, Din, output Dout, Hit);
endinterface

// File: rtl/timer_bank.sv
// Bank of NUM_TIMERS independent down-counting timers with per-channel
// one-shot/auto-reload mode, interrupt mask and sticky pending bit.
module timer_bank #(
    parameter int          NUM_TIMERS = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_7F00,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    timer_bank_if.slave           bus,
    output logic [NUM_TIMERS-1:0] IRQ,
    output logic                  IRQ_any
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, EXPIRE} state_t;

    // One bit wider than the address so a window ending at 4 GiB still compares correctly.
    localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(16 * NUM_TIMERS);

    logic [31:0] byte_addr;
    logic        hit;
    logic [3:0]  chan_sel;
    logic [1:0]  reg_sel;
    logic [31:0] rd_mux;
    logic [31:0] chan_rdata [NUM_TIMERS];

    assign byte_addr = {bus.Addr, 2'b00};
    assign hit       = (byte_addr >= BASE_ADDR) && ({1'b0, byte_addr} < END_ADDR);
    // Base is 16-byte aligned, so subtracting only bits [7:4] never needs a borrow.
    assign chan_sel  = byte_addr[7:4] - BASE_ADDR[7:4];
    assign reg_sel   = bus.Addr[1:0];
    assign bus.Hit   = hit;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (hit && (chan_sel == 4'(i))) begin
                rd_mux = chan_rdata[i];
            end
        end
    end

    assign bus.Dout = rd_mux;
    assign IRQ_any  = |IRQ;

    generate
        for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_chan
            state_t                 state_reg, state_next;
            logic                   en_reg, en_next;
            logic [1:0]             mode_reg, mode_next;
            logic                   im_reg, im_next;
            logic                   pend_reg, pend_next;
            logic [CNT_WIDTH-1:0]   preset_reg, preset_next;
            logic [CNT_WIDTH-1:0]   count_reg, count_next;
            logic                   sel;
            logic                   wr_ctrl, wr_preset, wr_status;

            assign sel       = hit && (chan_sel == 4'(gi));
            assign wr_ctrl   = bus.WE && sel && (reg_sel == 2'd0);
            assign wr_preset = bus.WE && sel && (reg_sel == 2'd1);
            assign wr_status = bus.WE && sel && (reg_sel == 2'd3);

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg  <= IDLE;
                    en_reg     <= 1'b0;
                    mode_reg   <= 2'b00;
                    im_reg     <= 1'b0;
                    pend_reg   <= 1'b0;
                    preset_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    state_reg  <= state_next;
                    en_reg     <= en_next;
                    mode_reg   <= mode_next;
                    im_reg     <= im_next;
                    pend_reg   <= pend_next;
                    preset_reg <= preset_next;
                    count_reg  <= count_next;
                end
            end

            always_comb begin
                state_next  = state_reg;
                en_next     = en_reg;
                mode_next   = mode_reg;
                im_next     = im_reg;
                pend_next   = pend_reg;
                preset_next = preset_reg;
                count_next  = count_reg;

                // Clear is applied before the FSM so a same-cycle expiry wins.
                if (wr_status && bus.Din[0]) begin
                    pend_next = 1'b0;
                end

                case (state_reg)
                    IDLE: ;
                    LOAD: begin
                        count_next = preset_reg;
                        state_next = CNT;
                    end
                    CNT: begin
                        if (count_reg != '0) begin
                            count_next = count_reg - CNT_WIDTH'(1);
                        end else begin
                            state_next = EXPIRE;
                            pend_next  = 1'b1;
                        end
                    end
                    EXPIRE: begin
                        if (mode_reg == 2'b01) begin
                            state_next = LOAD;
                        end else begin
                            state_next = IDLE;
                            en_next    = 1'b0;
                        end
                    end
                    default: state_next = IDLE;
                endcase

                if (wr_preset) begin
                    preset_next = bus.Din[CNT_WIDTH-1:0];
                end

                if (wr_ctrl) begin
                    mode_next = bus.Din[2:1];
                    im_next   = bus.Din[3];
                    if (!bus.Din[0]) begin
                        state_next = IDLE;
                        en_next    = 1'b0;
                        count_next = count_reg;
                    end else if (state_reg == IDLE) begin
                        state_next = LOAD;
                        en_next    = 1'b1;
                    end
                end
            end

            assign chan_rdata[gi] = (reg_sel == 2'd0) ? {28'd0, im_reg, mode_reg, en_reg} :
                                    (reg_sel == 2'd1) ? 32'(preset_reg) :
                                    (reg_sel == 2'd2) ? 32'(count_reg) :
                                                        {31'd0, pend_reg};

            assign IRQ[gi] = pend_reg & im_reg;
        end
    endgenerate
endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: an elapsed-time channel model checked every
// cycle, plus hand-computed expectations at the interesting points.
module tb_timer_bank;
    localparam int          N    = 2;
    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] irq;
    logic         irq_any;
    logic         chk_en = 1'b0;
    int           n_vec  = 0;
    int           n_err  = 0;

    timer_bank_if bus ();

    timer_bank #(.NUM_TIMERS(N), .BASE_ADDR(BASE), .CNT_WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .IRQ     (irq),
        .IRQ_any (irq_any)
    );

    always #5 clk = ~clk;

    // Channel model: each run is a timeline indexed by edges since enable/reload.
    logic        m_en     [N];
    logic [1:0]  m_mode   [N];
    logic        m_im     [N];
    logic        m_pend   [N];
    logic [31:0] m_preset [N];
    logic        m_active [N];
    int          m_k      [N];
    logic [31:0] m_p      [N];
    logic [31:0] m_hold   [N];

    int cnt_exp [9] = '{0, 5, 4, 3, 2, 1, 0, 0, 0};
    int irq_exp [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};

    function automatic logic [31:0] m_count(int i);
        if (!m_active[i] || m_k[i] == 0) return m_hold[i];
        if (m_k[i] <= int'(m_p[i]) + 1) return m_p[i] - 32'(m_k[i] - 1);
        return 32'd0;
    endfunction

    function automatic logic m_hit(logic [31:0] b);
        return (longint'(b) >= longint'(BASE)) && (longint'(b) < longint'(BASE) + 16 * N);
    endfunction

    function automatic logic [31:0] m_read(logic [31:0] b);
        int ch;
        if (!m_hit(b)) return 32'd0;
        ch = int'((b - BASE) >> 4);
        case (b[3:2])
            2'd0:    return {28'd0, m_im[ch], m_mode[ch], m_en[ch]};
            2'd1:    return m_preset[ch];
            2'd2:    return m_count(ch);
            default: return {31'd0, m_pend[ch]};
        endcase
    endfunction

    function automatic logic [N-1:0] m_irq();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_pend[i] & m_im[i];
        return r;
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] b;
        logic [31:0] cur [N];
        logic        was_act [N];
        int          ch;
        b = {bus.Addr, 2'b00};
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_en[i] = 0; m_mode[i] = 0; m_im[i] = 0; m_pend[i] = 0;
                m_preset[i] = 0; m_active[i] = 0; m_k[i] = 0; m_p[i] = 0; m_hold[i] = 0;
            end
        end else begin
            ch = int'((b - BASE) >> 4);
            for (int i = 0; i < N; i++) begin
                cur[i]     = m_count(i);
                was_act[i] = m_active[i];
            end
            if (bus.WE && m_hit(b) && b[3:2] == 2'd3 && bus.Din[0]) m_pend[ch] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (m_active[i]) begin
                    m_k[i]++;
                    if (m_k[i] == 1) m_p[i] = m_preset[i];
                    if (m_k[i] == int'(m_p[i]) + 2) begin
                        m_pend[i] = 1'b1;
                    end else if (m_k[i] == int'(m_p[i]) + 3) begin
                        m_hold[i] = 0;
                        if (m_mode[i] == 2'b01) m_k[i] = 0;
                        else begin m_active[i] = 0; m_en[i] = 0; end
                    end
                end
            end
            if (bus.WE && m_hit(b)) begin
                if (b[3:2] == 2'd0) begin
                    m_mode[ch] = bus.Din[2:1];
                    m_im[ch]   = bus.Din[3];
                    if (!bus.Din[0]) begin
                        m_hold[ch] = cur[ch]; m_active[ch] = 0; m_en[ch] = 0;
                    end else if (!was_act[ch]) begin
                        m_hold[ch] = cur[ch]; m_active[ch] = 1; m_k[ch] = 0; m_en[ch] = 1;
                    end
                end else if (b[3:2] == 2'd1) begin
                    m_preset[ch] = bus.Din;
                end
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin : compare
            logic [31:0] b;
            b = {bus.Addr, 2'b00};
            cmp("model_hit",     32'(bus.Hit), 32'(m_hit(b)));
            cmp("model_dout",    bus.Dout,     m_read(b));
            cmp("model_irq",     32'(irq),     32'(m_irq()));
            cmp("model_irq_any", 32'(irq_any), 32'(|m_irq()));
        end
    end

    task automatic drive(input logic we, input logic [31:0] b, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.WE   = we;
        bus.Addr = b[31:2];
        bus.Din  = d;
        $display("cycle t=%0t we=%0b addr=0x%08h din=0x%08h", $time, we, b, d);
    endtask

    task automatic wr(input logic [31:0] b, input logic [31:0] d);
        drive(1'b1, b, d);
    endtask

    task automatic rd(input logic [31:0] b);
        drive(1'b0, b, 32'd0);
    endtask

    task automatic rst_rd(input logic r, input logic [31:0] b);
        @(posedge clk);
        #1;
        reset    = r;
        bus.WE   = 1'b0;
        bus.Addr = b[31:2];
        bus.Din  = 32'd0;
        $display("cycle t=%0t reset=%0b addr=0x%08h", $time, r, b);
    endtask

    initial begin
        bus.WE   = 1'b0;
        bus.Addr = 30'h1FC0;
        bus.Din  = 32'd0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);

        // Reset state and out-of-range decode
        rst_rd(1'b0, 32'h7F00); @(negedge clk); cmp("rst_ctrl0",   bus.Dout, 32'd0);
        rd(32'h7F04);           @(negedge clk); cmp("rst_preset0", bus.Dout, 32'd0);
        rd(32'h7F08);           @(negedge clk); cmp("rst_count0",  bus.Dout, 32'd0);
        rd(32'h7F0C);           @(negedge clk); cmp("rst_status0", bus.Dout, 32'd0);
                                                cmp("rst_irq",     32'(irq), 32'd0);
        rd(32'h7F20);           @(negedge clk); cmp("oob_hit",     32'(bus.Hit), 32'd0);
                                                cmp("oob_dout",    bus.Dout, 32'd0);

        // One-shot on channel 0, P=5
        wr(32'h7F04, 32'd5);
        wr(32'h7F00, 32'h9);
        for (int i = 0; i < 9; i++) begin
            rd(32'h7F08);
            @(negedge clk);
            cmp("os_count", bus.Dout, 32'(cnt_exp[i]));
            cmp("os_irq0",  32'(irq[0]), 32'(irq_exp[i]));
        end
        rd(32'h7F00);           @(negedge clk); cmp("os_ctrl_done", bus.Dout, 32'h8);
        wr(32'h7F0C, 32'd1);
        rd(32'h7F0C);           @(negedge clk); cmp("os_pend_clr",  bus.Dout, 32'd0);

        // Auto-reload on channel 1, P=2: expiries at E4, E9, E14
        wr(32'h7F14, 32'd2);
        wr(32'h7F10, 32'hB);
        for (int i = 0; i < 6; i++) begin
            rd(32'h7F1C);
            @(negedge clk);
            cmp("ar_pend", bus.Dout, 32'(i >= 4));
        end
        wr(32'h7F1C, 32'd1);
        rd(32'h7F1C);           @(negedge clk); cmp("ar_irq_clr", 32'(irq[1]), 32'd0);
                                                cmp("ch0_quiet",  32'(irq[0]), 32'd0);
        rd(32'h7F1C);
        rd(32'h7F1C);           @(negedge clk); cmp("ar_irq_re",  32'(irq[1]), 32'd1);
        wr(32'h7F1C, 32'd1);
        rd(32'h7F1C);           @(negedge clk); cmp("ar_clr2",    32'(irq[1]), 32'd0);
        rd(32'h7F1C);
        wr(32'h7F1C, 32'd1);
        rd(32'h7F1C);           @(negedge clk); cmp("ar_set_wins", bus.Dout, 32'd1);
                                                cmp("ar_set_irq",  32'(irq[1]), 32'd1);
        wr(32'h7F10, 32'd0);
        wr(32'h7F1C, 32'd1);
        rd(32'h7F18);

        // Mid-count disable on channel 0, then a masked expiry
        wr(32'h7F00, 32'h9);
        rd(32'h7F08); rd(32'h7F08); rd(32'h7F08);
        wr(32'h7F00, 32'h0);
        rd(32'h7F08);           @(negedge clk); cmp("mid_hold", bus.Dout, 32'd3);
        repeat (8) rd(32'h7F08);
        @(negedge clk);                         cmp("mid_hold_late", bus.Dout, 32'd3);
                                                cmp("mid_noirq",     32'(irq_any), 32'd0);
        wr(32'h7F04, 32'd1);
        wr(32'h7F00, 32'h1);
        repeat (4) rd(32'h7F0C);
        @(negedge clk);                         cmp("masked_pend", bus.Dout, 32'd1);
                                                cmp("masked_irq0", 32'(irq[0]), 32'd0);
        wr(32'h7F00, 32'h8);
        rd(32'h7F00);           @(negedge clk); cmp("unmask_irq0",    32'(irq[0]), 32'd1);
                                                cmp("unmask_irq_any", 32'(irq_any), 32'd1);
                                                cmp("unmask_ctrl",    bus.Dout, 32'h8);

        // MODE=10 behaves as one-shot but reads back; COUNT writes ignored; P=0
        wr(32'h7F0C, 32'd1);
        wr(32'h7F04, 32'd0);
        wr(32'h7F08, 32'h55);
        rd(32'h7F08);           @(negedge clk); cmp("count_wr_ign", bus.Dout, 32'd0);
        wr(32'h7F00, 32'hD);
        rd(32'h7F00);           @(negedge clk); cmp("m10_ctrl_run", bus.Dout, 32'hD);
        rd(32'h7F0C);
        rd(32'h7F0C);           @(negedge clk); cmp("p0_pend_e2",   bus.Dout, 32'd1);
        rd(32'h7F00);           @(negedge clk); cmp("m10_ctrl_end", bus.Dout, 32'hC);

        // Reset while channel 1 is mid-count
        wr(32'h7F10, 32'hB);
        rd(32'h7F18); rd(32'h7F18);
        rst_rd(1'b1, 32'h7F18); @(negedge clk); cmp("pre_rst_count1", bus.Dout, 32'd1);
        rst_rd(1'b0, 32'h7F18); @(negedge clk); cmp("rst_count1",     bus.Dout, 32'd0);
                                                cmp("rst_irq_all",    32'(irq), 32'd0);
                                                cmp("rst_irq_any",    32'(irq_any), 32'd0);
        rd(32'h7F10);           @(negedge clk); cmp("rst_ctrl1",   bus.Dout, 32'd0);
        rd(32'h7F14);           @(negedge clk); cmp("rst_preset1", bus.Dout, 32'd0);
        rd(32'h7F0C);           @(negedge clk); cmp("rst_status0", bus.Dout, 32'd0);
        repeat (6) rd(32'h7F1C);
        @(negedge clk);                         cmp("rst_no_irq",  32'(irq_any), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
